seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL, default 1000: cycles each digit is driven per visit; legal range 1..65535.
REQ-002 The block SHALL have parameter GAP, default 8: all-digits-off cycles after each visit; legal range 0..255, where 0 means no gap.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port wr_en, input, 1 bit: write strobe into the digit buffer.
REQ-006 The block SHALL have port wr_idx, input, 3 bits: digit index to write, 0..7.
REQ-007 The block SHALL have port wr_data, input, 4 bits: hex nibble to store.
REQ-008 The block SHALL have port digit_en, input, 8 bits: per-digit enable, where 0 blanks that digit.
REQ-009 The block SHALL have port dp_mask, input, 8 bits: per-digit decimal point, where 1 lights the DP.
REQ-010 The block SHALL have port dig_sel_n, output, 8 bits: active-low one-hot digit anode select.
REQ-011 The block SHALL have port nibble, output, 4 bits: value for the external hex-to-segment decoder.
REQ-012 The block SHALL have port blank, output, 1 bit: high when the segment drive must be forced off.
REQ-013 The block SHALL have port dp_n, output, 1 bit: active-low decimal point for the current digit.
REQ-014 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse marking the end of a full 8-digit scan.

Function
REQ-015 The block SHALL hold an 8x4-bit digit buffer; when wr_en=1, buf[wr_idx] <= wr_data at the clock edge.
REQ-016 All outputs SHALL be combinational functions of registered state (state, idx, cnt, buf) only, so a write is visible on nibble the cycle after wr_en.
REQ-017 The block SHALL implement a two-state FSM, SHOW and GAP, with a 3-bit digit index idx and a 16-bit dwell counter cnt.
REQ-018 In SHOW: cnt increments each cycle; at cnt==DWELL-1, cnt <= 0 and the FSM goes to GAP, or advances idx and stays in SHOW if GAP==0.
REQ-019 In GAP: cnt increments each cycle; at cnt==GAP-1, cnt <= 0, idx advances and the FSM goes to SHOW.
REQ-020 Each digit SHALL therefore occupy exactly DWELL+GAP cycles, and a frame SHALL be exactly 8*(DWELL+GAP) cycles.
REQ-021 idx SHALL advance modulo 8 (7 -> 0), with no skipping of disabled digits, so the scan period is fixed.
REQ-022 In SHOW with digit_en[idx]=1: dig_sel_n = ~(1<<idx); nibble = buf[idx]; blank = 0; dp_n = ~dp_mask[idx].
REQ-023 In SHOW with digit_en[idx]=0: dig_sel_n = 8'hFF; blank = 1; dp_n = 1; nibble = buf[idx].
REQ-024 In GAP: dig_sel_n = 8'hFF; blank = 1; dp_n = 1; nibble = buf[idx].
REQ-025 frame_tick SHALL be 1 exactly in the last cycle of digit 7's visit: GAP with cnt==GAP-1, or SHOW with cnt==DWELL-1 when GAP==0.
REQ-026 A write to buf[idx] during that digit's SHOW SHALL change nibble the next cycle without disturbing cnt or the FSM.
REQ-027 A write to any index during GAP or to another digit SHALL have no effect on the outputs until that digit is shown.
REQ-028 Changes to digit_en and dp_mask SHALL take effect in the same cycle, since they are unregistered.
REQ-029 dig_sel_n SHALL never have more than one bit low in any cycle.

Reset
REQ-030 While rst=1, the block SHALL load state=SHOW, idx=0, cnt=0 and all buf entries = 4'h0.
REQ-031 While rst=1, outputs SHALL be forced to dig_sel_n=8'hFF, blank=1, dp_n=1, frame_tick=0 and nibble=4'h0.
REQ-032 A write with wr_en=1 in the same cycle as rst=1 SHALL be ignored, with reset winning.
REQ-033 Reset asserted mid-scan SHALL abort the scan; in the first cycle after release, digit 0 SHALL show 0 with dig_sel_n=8'hFE when digit_en[0]=1.

Verification (DWELL=4, GAP=2, digit_en=8'hFF unless stated)
REQ-034 Bench SHALL check: release reset, no writes -> dig_sel_n is FE for 4 cycles, FF for 2, FD for 4, and so on; nibble=0; frame_tick pulses once every 48 cycles.
REQ-035 Bench SHALL check: write idx0..7 with data 1..8 -> during each SHOW, nibble equals idx+1 and dig_sel_n has the correct single bit low.
REQ-036 Bench SHALL check: write buf[idx]=4'hA in cycle 2 of that digit's SHOW -> nibble=A from cycle 3, and the SHOW still ends after 4 cycles.
REQ-037 Bench SHALL check: digit_en=8'h0F, dp_mask=8'h01 -> digits 4..7 give dig_sel_n=FF and blank=1; digit 0 gives dp_n=0; all others give dp_n=1.
REQ-038 Bench SHALL check: GAP=0 build -> no all-FF cycles between digits; frame_tick every 32 cycles, on digit 7's last SHOW cycle.
REQ-039 Bench SHALL check: rst=1 during digit 5's GAP together with wr_en=1 -> the write is dropped, and after release digit 0 shows 0 from cycle 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - eight-digit multiplexed seven-segment scan controller
//
// Purpose: holds an 8x4-bit digit buffer and scans it onto a common-anode
// display. Each digit is driven for DWELL cycles and then followed by GAP
// all-off cycles. The 4-bit value is handed to an external hex-to-segment
// decoder.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   wr_en      - digit buffer write strobe
//   wr_idx     - digit index to write (0..7)
//   wr_data    - hex nibble to store
//   digit_en   - per-digit enable (0 blanks that digit)
//   dp_mask    - per-digit decimal point (1 lights it)
//   dig_sel_n  - active-low one-hot anode select
//   nibble     - value for the external segment decoder
//   blank      - forces the segment drive off
//   dp_n       - active-low decimal point for the current digit
//   frame_tick - one-cycle pulse on the last cycle of a full 8-digit scan
module seg_scan_ctrl #(
    parameter int DWELL = 1000,
    parameter int GAP   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  logic [3:0] wr_data,
    input  logic [7:0] digit_en,
    input  logic [7:0] dp_mask,
    output logic [7:0] dig_sel_n,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       dp_n,
    output logic       frame_tick
);

    typedef enum logic {
        S_SHOW = 1'b0,
        S_GAP  = 1'b1
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    // With no gap the GAP state is unreachable; the value only has to be legal.
    localparam logic [15:0] GAP_LAST   = (GAP == 0) ? 16'd0 : 16'(GAP - 1);
    localparam bit          NO_GAP     = (GAP == 0);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  digit_buf_q [8];
    logic [3:0]  digit_buf_d [8];

    logic show_last;
    logic gap_last;

    assign show_last = (state_q == S_SHOW) && (cnt_q == DWELL_LAST);
    assign gap_last  = (state_q == S_GAP)  && (cnt_q == GAP_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 16'd1;
        for (int i = 0; i < 8; i++) begin
            digit_buf_d[i] = digit_buf_q[i];
        end
        if (wr_en) begin
            digit_buf_d[wr_idx] = wr_data;
        end

        if (show_last) begin
            cnt_d = 16'd0;
            if (NO_GAP) begin
                idx_d = idx_q + 3'd1;
            end else begin
                state_d = S_GAP;
            end
        end else if (gap_last) begin
            cnt_d   = 16'd0;
            idx_d   = idx_q + 3'd1;
            state_d = S_SHOW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SHOW;
            idx_q   <= 3'd0;
            cnt_q   <= 16'd0;
            for (int i = 0; i < 8; i++) begin
                digit_buf_q[i] <= 4'h0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 8; i++) begin
                digit_buf_q[i] <= digit_buf_d[i];
            end
        end
    end

    // Outputs depend only on registered state plus the unregistered enable
    // and DP masks; rst overrides everything so the display is dark at once.
    always_comb begin
        dig_sel_n  = 8'hFF;
        nibble     = digit_buf_q[idx_q];
        blank      = 1'b1;
        dp_n       = 1'b1;
        frame_tick = (idx_q == 3'd7) && (gap_last || (NO_GAP && show_last));

        if (rst) begin
            nibble     = 4'h0;
            frame_tick = 1'b0;
        end else if ((state_q == S_SHOW) && digit_en[idx_q]) begin
            dig_sel_n = ~(8'b1 << idx_q);
            blank     = 1'b0;
            dp_n      = ~dp_mask[idx_q];
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl (gapped and gapless builds)
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [3:0] wr_data;
    logic [7:0] digit_en;
    logic [7:0] dp_mask;

    logic [7:0] a_sel, b_sel;
    logic [3:0] a_nib, b_nib;
    logic       a_blank, b_blank, a_dp, b_dp, a_ft, b_ft;

    int total = 0;
    int bad   = 0;

    // Reference: time since reset, decomposed arithmetically into digit/offset.
    int         t_a, t_b;
    logic [3:0] bufm [8];

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DWELL(4), .GAP(2)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .digit_en(digit_en), .dp_mask(dp_mask),
        .dig_sel_n(a_sel), .nibble(a_nib), .blank(a_blank), .dp_n(a_dp), .frame_tick(a_ft)
    );

    seg_scan_ctrl #(.DWELL(4), .GAP(0)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .digit_en(digit_en), .dp_mask(dp_mask),
        .dig_sel_n(b_sel), .nibble(b_nib), .blank(b_blank), .dp_n(b_dp), .frame_tick(b_ft)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {dig_sel_n, nibble, blank, dp_n, frame_tick}.
    function automatic logic [14:0] model_out(input int t, input int d, input int g);
        int per, p, dig, off;
        logic [7:0] sel;
        logic       bl, dp, ft;
        per = d + g;
        p   = t % (8 * per);
        dig = p / per;
        off = p % per;
        if (rst) return {8'hFF, 4'h0, 1'b1, 1'b1, 1'b0};
        sel = 8'hFF; bl = 1'b1; dp = 1'b1;
        ft  = (p == 8 * per - 1);
        if (off < d && digit_en[dig]) begin
            sel = 8'hFF;
            sel[dig] = 1'b0;
            bl = 1'b0;
            dp = ~dp_mask[dig];
        end
        return {sel, bufm[dig], bl, dp, ft};
    endfunction

    task automatic check_all();
        logic [14:0] e;
        e = model_out(t_a, 4, 2);
        chk("a_sel", 16'(a_sel), 16'(e[14:7]));
        chk("a_nibble", 16'(a_nib), 16'(e[6:3]));
        chk("a_blank", 16'(a_blank), 16'(e[2]));
        chk("a_dp_n", 16'(a_dp), 16'(e[1]));
        chk("a_frame_tick", 16'(a_ft), 16'(e[0]));
        chk("a_onehot", 16'($countones(~a_sel) <= 1), 16'd1);
        e = model_out(t_b, 4, 0);
        chk("b_sel", 16'(b_sel), 16'(e[14:7]));
        chk("b_nibble", 16'(b_nib), 16'(e[6:3]));
        chk("b_blank", 16'(b_blank), 16'(e[2]));
        chk("b_dp_n", 16'(b_dp), 16'(e[1]));
        chk("b_frame_tick", 16'(b_ft), 16'(e[0]));
        chk("b_onehot", 16'($countones(~b_sel) <= 1), 16'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            t_a = 0;
            t_b = 0;
            for (int i = 0; i < 8; i++) bufm[i] = 4'h0;
        end else begin
            t_a = (t_a + 1) % 48;
            t_b = (t_b + 1) % 32;
            if (wr_en) bufm[wr_idx] = wr_data;
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_all();
    endtask

    int ft_a_cnt, ft_b_cnt, ff_a_cnt, ff_b_cnt, guard;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_idx = 3'd0; wr_data = 4'h0;
        digit_en = 8'hFF; dp_mask = 8'h00;
        t_a = 0; t_b = 0;
        for (int i = 0; i < 8; i++) bufm[i] = 4'h0;

        // Reset state and free-running scan with no writes.
        do_reset();
        chk("rel_a_sel", 16'(a_sel), 16'h00FE);
        chk("rel_a_nib", 16'(a_nib), 16'h0000);
        ft_a_cnt = 0; ft_b_cnt = 0; ff_a_cnt = 0; ff_b_cnt = 0;
        for (int i = 0; i < 96; i++) begin
            tick();
            ft_a_cnt += int'(a_ft);
            ft_b_cnt += int'(b_ft);
            ff_a_cnt += int'(a_sel == 8'hFF);
            ff_b_cnt += int'(b_sel == 8'hFF);
        end
        chk("a_ticks_96", 16'(ft_a_cnt), 16'd2);
        chk("b_ticks_96", 16'(ft_b_cnt), 16'd3);
        chk("a_gap_cycles_96", 16'(ff_a_cnt), 16'd32);
        chk("b_gap_cycles_96", 16'(ff_b_cnt), 16'd0);

        // Load digits 0..7 with 1..8 and scan a frame.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_idx = 3'(i); wr_data = 4'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 96; i++) tick();

        // Overwrite digit 3 on the second cycle of its SHOW.
        guard = 0;
        while (!((t_a / 6) % 8 == 3 && t_a % 6 == 1) && guard < 100) begin
            tick();
            guard++;
        end
        chk("wait_d3_timeout", 16'(guard < 100), 16'd1);
        wr_en = 1'b1; wr_idx = 3'd3; wr_data = 4'hA;
        tick();
        wr_en = 1'b0;
        chk("d3_nib_cycle3", 16'(a_nib), 16'h000A);
        chk("d3_sel_cycle3", 16'(a_sel), 16'h00F7);
        tick();
        chk("d3_sel_cycle4", 16'(a_sel), 16'h00F7);
        tick();
        chk("d3_sel_gap", 16'(a_sel), 16'h00FF);

        // Partial enable with one decimal point.
        digit_en = 8'h0F; dp_mask = 8'h01;
        #1;
        check_all();
        for (int i = 0; i < 96; i++) tick();
        digit_en = 8'hFF; dp_mask = 8'h00;

        // Reset with a colliding write during digit 5's gap.
        guard = 0;
        while (!((t_a / 6) % 8 == 5 && t_a % 6 >= 4) && guard < 100) begin
            tick();
            guard++;
        end
        chk("wait_d5gap_timeout", 16'(guard < 100), 16'd1);
        rst = 1'b1; wr_en = 1'b1; wr_idx = 3'd0; wr_data = 4'hF;
        tick();
        chk("rst_sel", 16'(a_sel), 16'h00FF);
        chk("rst_nib", 16'(a_nib), 16'h0000);
        chk("rst_ft", 16'(a_ft), 16'h0000);
        rst = 1'b0; wr_en = 1'b0;
        #1;
        check_all();
        chk("after_rst_sel", 16'(a_sel), 16'h00FE);
        chk("after_rst_nib", 16'(a_nib), 16'h0000);
        tick();
        chk("after_rst_nib_c1", 16'(a_nib), 16'h0000);

        // Random writes, masks and occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_idx   = 3'($urandom_range(0, 7));
            wr_data  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
            if ($urandom_range(0, 15) == 0) dp_mask  = 8'($urandom);
            #1;
            check_all();
            tick();
        end
        rst = 1'b0; wr_en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
